// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants, opcodes and state type for the
// RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN        = 32;
  localparam int CALC_CYCLES = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  function automatic logic [XLEN-1:0] mag(
    input logic [XLEN-1:0] x,
    input logic            sgn
  );
    return (sgn & x[XLEN-1]) ? -x : x;
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// muldiv_div_step: one restoring-division iteration, producing
// the next partial remainder and one quotient bit.
module muldiv_div_step #(
  parameter int XLEN = muldiv_pkg::XLEN
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic            bit_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_o
);

  logic [XLEN-1:0] trial;

  assign trial = {rem_i[XLEN-2:0], bit_i};
  assign q_o   = {rem_i, bit_i} >= {1'b0, divisor_i};
  // the true difference is below 2^XLEN, so wrap-around is exact
  assign rem_o = q_o ? (trial - divisor_i) : trial;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit with direct
// register-file write port. MULDIV_FAST_MUL_EN: single-cycle MUL*.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = muldiv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr,
  output logic            busy,
  output logic            done,
  output logic            wr_en,
  output logic [4:0]      wr_addr,
  output logic [XLEN-1:0] wr_data
);

  localparam logic [XLEN-1:0] MIN_NEG =
    {1'b1, {(XLEN-1){1'b0}}};

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic            neg_q, neg_d;
  logic            rneg_q, rneg_d;
  logic [5:0]      cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            wr_en_q, wr_en_d;
  logic [4:0]      wr_addr_q, wr_addr_d;
  logic [XLEN-1:0] wr_data_q, wr_data_d;

  logic            is_div, sgn1, sgn2;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] mag1, mag2, spec_res;

  assign is_div = funct3[2];
  assign sgn1 = (funct3 == F3_MULH) ||
                (funct3 == F3_MULHSU) ||
                (funct3 == F3_DIV) ||
                (funct3 == F3_REM);
  assign sgn2 = (funct3 == F3_MULH) ||
                (funct3 == F3_DIV) ||
                (funct3 == F3_REM);
  assign div_zero = is_div && (rs2_data == '0);
  assign div_ovf  = is_div && sgn2 &&
                    (rs1_data == MIN_NEG) &&
                    (rs2_data == '1);
  assign mag1 = mag(rs1_data, sgn1);
  assign mag2 = mag(rs2_data, sgn2);

  always_comb begin
    spec_res = '0;
    unique case (1'b1)
      div_zero: spec_res = funct3[1] ? rs1_data : '1;
      div_ovf:  spec_res = funct3[1] ? '0 : MIN_NEG;
      default:  spec_res = '0;
    endcase
  end

  logic            fast_ok;
  logic [XLEN-1:0] fast_res;
`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fa, fb;
  logic        [2*XLEN-1:0] fp;
  assign fa = {sgn1 & rs1_data[XLEN-1], rs1_data};
  assign fb = {sgn2 & rs2_data[XLEN-1], rs2_data};
  assign fp = (2*XLEN)'(fa) * (2*XLEN)'(fb);
  assign fast_ok  = !is_div;
  assign fast_res = (funct3 == F3_MUL) ?
                    fp[XLEN-1:0] : fp[2*XLEN-1:XLEN];
`else
  assign fast_ok  = 1'b0;
  assign fast_res = '0;
`endif

  logic [XLEN-1:0]   drem, hi_n, lo_n, calc_res;
  logic              dq;
  logic [XLEN:0]     msum;
  logic [2*XLEN-1:0] prod;

  muldiv_div_step #(.XLEN(XLEN)) u_step (
    .rem_i     (hi_q),
    .bit_i     (lo_q[XLEN-1]),
    .divisor_i (opnd_q),
    .rem_o     (drem),
    .q_o       (dq)
  );

  // multiply shares hi/lo: {hi,lo} shifts right, adding opnd
  assign msum = {1'b0, hi_q} +
                (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign hi_n = op_q[2] ? drem : msum[XLEN:1];
  assign lo_n = op_q[2] ? {lo_q[XLEN-2:0], dq}
                        : {msum[0], lo_q[XLEN-1:1]};
  assign prod = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};

  always_comb begin
    calc_res = '0;
    unique case (1'b1)
      op_q == F3_MUL:
        calc_res = prod[XLEN-1:0];
      !op_q[2] && (op_q != F3_MUL):
        calc_res = prod[2*XLEN-1:XLEN];
      op_q[2] && op_q[1]:
        calc_res = rneg_q ? -hi_n : hi_n;
      op_q[2] && !op_q[1]:
        calc_res = neg_q ? -lo_n : lo_n;
      default:
        calc_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d   = funct3;
          rd_d   = rd_addr;
          cnt_d  = '0;
          hi_d   = '0;
          lo_d   = is_div ? mag1 : mag2;
          opnd_d = is_div ? mag2 : mag1;
          neg_d  = (sgn1 & rs1_data[XLEN-1]) ^
                   (sgn2 & rs2_data[XLEN-1]);
          rneg_d = sgn1 & rs1_data[XLEN-1];
          if (div_zero || div_ovf || fast_ok) begin
            state_d   = DONE;
            done_d    = 1'b1;
            wr_en_d   = rd_addr != '0;
            wr_addr_d = rd_addr;
            wr_data_d = fast_ok ? fast_res : spec_res;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        hi_d  = hi_n;
        lo_d  = lo_n;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(CALC_CYCLES-1)) begin
          state_d   = DONE;
          done_d    = 1'b1;
          wr_en_d   = rd_q != '0;
          wr_addr_d = rd_q;
          wr_data_d = calc_res;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign busy    = state_q != IDLE;
  assign done    = done_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit, checking
// results, latency, write enable, holds and reset behaviour.
module tb_muldiv_unit;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_addr;
  logic        busy;
  logic        done;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  int checks = 0;
  int errors = 0;

  muldiv_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .funct3   (funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd_addr  (rd_addr),
    .busy     (busy),
    .done     (done),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic run(
    input string       tag,
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [4:0]  rd,
    input logic [31:0] exp,
    input int          exp_lat,
    input int          glitch
  );
    int lat;
    wait_idle();
    start    = 1'b1;
    funct3   = f3;
    rs1_data = a;
    rs2_data = b;
    rd_addr  = rd;
    @(posedge clk);
    #1;
    start    = 1'b0;
    rs1_data = ~a;
    rs2_data = ~b;
    rd_addr  = ~rd;
    lat = 1;
    while (!done && lat < 100) begin
      if (lat == glitch) begin
        start    = 1'b1;
        funct3   = F3_MUL;
        rs1_data = 32'd3;
        rs2_data = 32'd3;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_data"}, wr_data, exp);
    check({tag, "_wen"}, 32'(wr_en), 32'(rd != 5'd0));
    check({tag, "_addr"}, 32'(wr_addr), 32'(rd));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    check({tag, "_done_off"}, 32'(done), 32'd0);
    check({tag, "_wen_off"}, 32'(wr_en), 32'd0);
    check({tag, "_hold"}, wr_data, exp);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    rst      = 1'b0;
    start    = 1'b0;
    funct3   = 3'd0;
    rs1_data = 32'd0;
    rs2_data = 32'd0;
    rd_addr  = 5'd0;
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wen", 32'(wr_en), 32'd0);
    check("rst_addr", 32'(wr_addr), 32'd0);
    check("rst_data", wr_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run("mul", F3_MUL, 32'd7, 32'hFFFFFFFD, 5'd1,
        32'hFFFFFFEB, MUL_LAT, 0);
    run("mulhu", F3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF,
        5'd2, 32'hFFFFFFFE, MUL_LAT, 0);
    run("mulh", F3_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF,
        5'd3, 32'h00000000, MUL_LAT, 0);
    run("mulhsu", F3_MULHSU, 32'hFFFFFFFF, 32'd2,
        5'd4, 32'hFFFFFFFF, MUL_LAT, 0);
    run("div_ovf", F3_DIV, 32'h80000000, 32'hFFFFFFFF,
        5'd5, 32'h80000000, 1, 0);
    run("rem_ovf", F3_REM, 32'h80000000, 32'hFFFFFFFF,
        5'd6, 32'h00000000, 1, 0);
    run("rem_neg", F3_REM, 32'hFFFFFFF9, 32'd2,
        5'd7, 32'hFFFFFFFF, 33, 0);
    run("div_neg", F3_DIV, 32'hFFFFFFF9, 32'd2,
        5'd8, 32'hFFFFFFFD, 33, 0);
    run("divu_z", F3_DIVU, 32'd100, 32'd0,
        5'd9, 32'hFFFFFFFF, 1, 0);
    run("remu_z", F3_REMU, 32'd100, 32'd0,
        5'd10, 32'd100, 1, 0);
    run("div_nd", F3_DIV, 32'd100, 32'hFFFFFFF9,
        5'd11, 32'hFFFFFFF2, 33, 0);
    run("remu", F3_REMU, 32'd100, 32'd7,
        5'd12, 32'd2, 33, 0);
    run("rd0", F3_MUL, 32'd3, 32'd5,
        5'd0, 32'd15, MUL_LAT, 0);
    run("glitch", F3_DIVU, 32'd100, 32'd7,
        5'd13, 32'd14, 33, 5);

    wait_idle();
    start    = 1'b1;
    funct3   = F3_DIVU;
    rs1_data = 32'd100;
    rs2_data = 32'd7;
    rd_addr  = 5'd14;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_wen", 32'(wr_en), 32'd0);
    check("mid_rst_data", wr_data, 32'd0);
    check("mid_rst_addr", 32'(wr_addr), 32'd0);
    @(negedge clk);
    rst  = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || wr_en) seen++;
    end
    check("mid_rst_quiet", 32'(seen), 32'd0);

    run("after_rst", F3_DIVU, 32'd100, 32'd7,
        5'd15, 32'd14, 33, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32; operand and result width, and only 32 is supported.
REQ-002 SHALL have port clk, input, 1 bit; rising-edge clock.
REQ-003 SHALL have port rst, input, 1 bit; asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit; issues an operation, sampled only in IDLE.
REQ-005 SHALL have port funct3, input, 3 bits; RV32M encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port rs1_data, input, 32 bits; dividend or multiplicand.
REQ-007 SHALL have port rs2_data, input, 32 bits; divisor or multiplier.
REQ-008 SHALL have port rd_addr, input, 5 bits; destination register index.
REQ-009 SHALL have port busy, output, 1 bit; high from the cycle after an accepted start through the DONE cycle.
REQ-010 SHALL have port done, output, 1 bit; one-cycle completion pulse.
REQ-011 SHALL have ports wr_en (1 bit), wr_addr (5 bits) and wr_data (32 bits), all outputs; they drive the register-file write port directly.

Function
REQ-012 SHALL use states IDLE, CALC and DONE.
REQ-013 SHALL latch funct3, both operands and rd_addr when start=1 in IDLE, then enter CALC or DONE per REQ-017/REQ-018.
REQ-014 SHALL ignore start outside IDLE, with no effect on the in-flight operation.
REQ-015 SHALL compute MUL (low 32 bits) and MULH/MULHSU/MULHU (high 32 bits of the 64-bit product) with correct signedness per operand.
REQ-016 SHALL compute DIV/REM and DIVU/REMU by iterative restoring division on magnitudes, producing 1 quotient bit per CALC cycle; quotient rounds toward zero, remainder takes the sign of the dividend.
REQ-017 SHALL spend exactly 32 CALC cycles, then one DONE cycle; start accepted at edge N gives done=1 in cycle N+33.
REQ-018 SHALL detect special cases at acceptance and go IDLE->DONE directly, giving done in cycle N+1:
- Divide by zero: quotient 0xFFFFFFFF, remainder = rs1_data.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0.
REQ-019 SHALL in DONE assert done=1, wr_addr=latched rd, wr_data=result, and wr_en=1 only if latched rd != 0; then return to IDLE.
REQ-020 SHALL hold wr_en=0 and done=0 in all non-DONE cycles; wr_data and wr_addr hold their last values.
REQ-021 SHALL accept a new start in the cycle immediately after DONE (back-to-back issue).

Reset
REQ-022 SHALL, while rst=0, force state IDLE and busy, done, wr_en, wr_addr and wr_data to 0, regardless of clk.
REQ-023 SHALL on reset mid-operation discard the operation, producing no done and no write afterwards.

Configuration
REQ-024 SHALL, with macro MULDIV_FAST_MUL_EN defined, compute MUL* with a single-cycle 33x33 signed product and go IDLE->DONE, giving done in cycle N+1.
REQ-025 SHALL, without MULDIV_FAST_MUL_EN, compute MUL* by iterative shift-add over 32 CALC cycles (done in cycle N+33); division timing is unaffected by the macro.

Structure
REQ-026 SHALL take from shared package muldiv_pkg: XLEN, the funct3 opcode constants, the state enum and the CALC cycle count (32).
REQ-027 SHALL place one restoring-division iteration (partial remainder, divisor -> next remainder, quotient bit) in combinational sub-module muldiv_div_step.

Verification
REQ-028 SHALL cover: MUL rs1=7, rs2=0xFFFFFFFD -> wr_data 0xFFFFFFEB; done in cycle N+33, or N+1 with MULDIV_FAST_MUL_EN.
REQ-029 SHALL cover: MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH of the same operands -> 0x00000000.
REQ-030 SHALL cover: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0, each done in N+1; REM 0xFFFFFFF9 % 2 -> 0xFFFFFFFF.
REQ-031 SHALL cover: DIVU 100 / 0 -> 0xFFFFFFFF and REMU 100 / 0 -> 100, each done in N+1.
REQ-032 SHALL cover: rd_addr=0 -> done pulses, wr_en stays 0; a start pulse during CALC is ignored and the result equals the first operation's.
REQ-033 SHALL cover: rst=0 asserted at CALC cycle 10 -> busy=0 immediately, no done or wr_en afterwards; a subsequent DIVU 100/7 -> 14 in cycle N+33.
